// File: rtl/h264_pkg.sv
// Shared widths, lane types and output FSM states for the H.264 4x4 forward core transform.
package h264_pkg;
    localparam int RES_W   = 9;
    localparam int HCOEF_W = 12;
    localparam int COEF_W  = 16;
    localparam int LANES   = 4;

    typedef logic [LANES-1:0][RES_W-1:0]   res_row_t;
    typedef logic [LANES-1:0][HCOEF_W-1:0] hrow_t;
    typedef logic [LANES-1:0][COEF_W-1:0]  coef_row_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OUT0,
        ST_OUT1,
        ST_OUT2,
        ST_OUT3
    } ostate_t;
endpackage

// File: rtl/h264_butterfly4.sv
// N independent 4-point H.264 forward butterflies, purely combinational.
// Inputs are sign-extended to OUT_W first so every sum is exact.
module h264_butterfly4 #(
    parameter int IN_W  = 9,
    parameter int OUT_W = 12,
    parameter int N     = 1
) (
    input  logic [N-1:0][3:0][IN_W-1:0]  x,
    output logic [N-1:0][3:0][OUT_W-1:0] y
);
    for (genvar g = 0; g < N; g++) begin : g_bf
        logic signed [OUT_W-1:0] a [4];
        logic signed [OUT_W-1:0] s03, d03, s12, d12;

        for (genvar k = 0; k < 4; k++) begin : g_ext
            assign a[k] = {{(OUT_W-IN_W){x[g][k][IN_W-1]}}, x[g][k]};
        end

        assign s03 = a[0] + a[3];
        assign d03 = a[0] - a[3];
        assign s12 = a[1] + a[2];
        assign d12 = a[1] - a[2];

        assign y[g][0] = s03 + s12;
        assign y[g][1] = (d03 <<< 1) + d12;
        assign y[g][2] = s03 - s12;
        assign y[g][3] = d03 - (d12 <<< 1);
    end
endmodule

// File: rtl/h264_coretransform.sv
// 4x4 forward core transform: horizontal pass on row entry into a ping-pong bank,
// vertical pass on readout, one registered coefficient row per beat.
module h264_coretransform #(
    parameter int RES_W  = h264_pkg::RES_W,
    parameter int COEF_W = h264_pkg::COEF_W
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  STROBEI,
    input  logic [4*RES_W-1:0]    DATAI,
    output logic                  READYI,
    output logic                  STROBEO,
    output logic [4*COEF_W-1:0]   DATAO,
    output logic                  LASTO,
    input  logic                  READYO
);
    import h264_pkg::*;

    logic [1:0] wr_row;
    logic       wr_bank;
    logic       rd_bank;
    logic [1:0] full;
    ostate_t    state;

    hrow_t bank [2][4];

    logic [0:0][3:0][HCOEF_W-1:0] hrow;
    logic [3:0][3:0][HCOEF_W-1:0] vin;
    logic [3:0][3:0][COEF_W-1:0]  vout;
    logic [3:0][COEF_W-1:0]       orow;

    logic       accept;
    logic       last_xfer;
    logic       vsel;
    logic [1:0] nxt_row;

    assign READYI    = ~full[wr_bank];
    assign accept    = STROBEI & READYI;
    assign last_xfer = (state == ST_OUT3) & READYO;
    // On the final beat the next row 0 may come from the other bank.
    assign vsel      = last_xfer ? ~rd_bank : rd_bank;

    h264_butterfly4 #(.IN_W(RES_W), .OUT_W(HCOEF_W), .N(1)) u_hor (
        .x (DATAI),
        .y (hrow)
    );

    // Column-major view of the read bank: vin[col][row].
    always_comb begin
        for (int j = 0; j < 4; j++)
            for (int i = 0; i < 4; i++)
                vin[j][i] = bank[vsel][i][j];
    end

    h264_butterfly4 #(.IN_W(HCOEF_W), .OUT_W(COEF_W), .N(4)) u_ver (
        .x (vin),
        .y (vout)
    );

    always_comb begin
        case (state)
            ST_OUT0: nxt_row = 2'd1;
            ST_OUT1: nxt_row = 2'd2;
            ST_OUT2: nxt_row = 2'd3;
            default: nxt_row = 2'd0;
        endcase
    end

    always_comb begin
        for (int j = 0; j < 4; j++)
            orow[j] = vout[j][nxt_row];
    end

    always_ff @(posedge CLK) begin
        if (accept)
            bank[wr_bank][wr_row] <= hrow[0];
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_row  <= 2'd0;
            wr_bank <= 1'b0;
            full    <= 2'b00;
        end else begin
            if (accept) begin
                wr_row <= wr_row + 2'd1;
                if (wr_row == 2'd3) begin
                    full[wr_bank] <= 1'b1;
                    wr_bank       <= ~wr_bank;
                end
            end
            if (last_xfer)
                full[rd_bank] <= 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state   <= ST_IDLE;
            STROBEO <= 1'b0;
            LASTO   <= 1'b0;
            DATAO   <= '0;
            rd_bank <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (full[rd_bank]) begin
                        state   <= ST_OUT0;
                        STROBEO <= 1'b1;
                        LASTO   <= 1'b0;
                        DATAO   <= orow;
                    end
                end
                ST_OUT0, ST_OUT1, ST_OUT2: begin
                    if (READYO) begin
                        state <= (state == ST_OUT0) ? ST_OUT1 :
                                 (state == ST_OUT1) ? ST_OUT2 : ST_OUT3;
                        LASTO <= (state == ST_OUT2);
                        DATAO <= orow;
                    end
                end
                ST_OUT3: begin
                    if (READYO) begin
                        rd_bank <= ~rd_bank;
                        LASTO   <= 1'b0;
                        if (full[~rd_bank]) begin
                            state <= ST_OUT0;
                            DATAO <= orow;
                        end else begin
                            state   <= ST_IDLE;
                            STROBEO <= 1'b0;
                        end
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    STROBEO <= 1'b0;
                    LASTO   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_h264_coretransform.sv
// Bench for h264_coretransform: Y = C*X*C^T reference, randomized blocks and backpressure.
module tb_h264_coretransform;
    logic        CLK;
    logic        RESET_N;
    logic        STROBEI;
    logic [35:0] DATAI;
    logic        READYI;
    logic        STROBEO;
    logic [63:0] DATAO;
    logic        LASTO;
    logic        READYO;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int blk_rdy_cyc = 0;
    int xb [4][4];
    logic [64:0] exp_q [$];
    logic [64:0] got_q [$];
    int got_cyc [$];

    h264_coretransform dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .STROBEI (STROBEI),
        .DATAI   (DATAI),
        .READYI  (READYI),
        .STROBEO (STROBEO),
        .DATAO   (DATAO),
        .LASTO   (LASTO),
        .READYO  (READYO)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (RESET_N && STROBEO && READYO) begin
            got_q.push_back({LASTO, DATAO});
            got_cyc.push_back(cyc);
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference: Y[r][k] = sum_i sum_j C[r][i] * X[i][j] * C[k][j]
    function automatic void model_push();
        const int C [4][4] = '{'{1, 1, 1, 1}, '{2, 1, -1, -2}, '{1, -1, -1, 1}, '{1, -2, 2, -1}};
        for (int r = 0; r < 4; r++) begin
            logic [63:0] row;
            row = '0;
            for (int k = 0; k < 4; k++) begin
                int s;
                s = 0;
                for (int i = 0; i < 4; i++)
                    for (int j = 0; j < 4; j++)
                        s += C[r][i] * xb[i][j] * C[k][j];
                row[16*k +: 16] = 16'(s);
            end
            exp_q.push_back({(r == 3), row});
        end
    endfunction

    function automatic void rand_block();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                xb[i][j] = int'($urandom_range(0, 511)) - 256;
    endfunction

    function automatic void fill_block(input int v);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                xb[i][j] = v;
    endfunction

    function automatic void flush();
        exp_q.delete();
        got_q.delete();
        got_cyc.delete();
    endfunction

    task automatic send_row(input int r, output int acc);
        int n;
        n = 0;
        for (int k = 0; k < 4; k++)
            DATAI[9*k +: 9] = 9'(xb[r][k]);
        STROBEI = 1'b1;
        @(negedge CLK);
        while (READYI !== 1'b1 && n < 300) begin
            n++;
            @(negedge CLK);
        end
        if (READYI !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL send_row: READYI is %b after 300 cycles, required 1", READYI);
        end
        if (r == 0) blk_rdy_cyc = cyc;
        @(posedge CLK);
        #1;
        STROBEI = 1'b0;
        acc = cyc;
    endtask

    task automatic send_block(output int acc);
        model_push();
        for (int r = 0; r < 4; r++)
            send_row(r, acc);
    endtask

    task automatic wait_got(input int n);
        int t;
        t = 0;
        while (got_q.size() < n && t < 300) begin
            @(posedge CLK);
            #1;
            t++;
        end
    endtask

    task automatic test_reset();
        RESET_N = 1'b1;
        #2;
        RESET_N = 1'b0;
        #1;
        vectors++;
        if (READYI !== 1'b1) begin miscompares++; $display("FAIL reset_readyi: got %b, required 1", READYI); end
        vectors++;
        if (STROBEO !== 1'b0) begin miscompares++; $display("FAIL reset_strobeo: got %b, required 0", STROBEO); end
        vectors++;
        if (LASTO !== 1'b0) begin miscompares++; $display("FAIL reset_lasto: got %b, required 0", LASTO); end
        vectors++;
        if (DATAO !== 64'd0) begin miscompares++; $display("FAIL reset_datao: got %h, required 0", DATAO); end
        repeat (3) @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        @(posedge CLK);
        #1;
        vectors++;
        if (READYI !== 1'b1 || STROBEO !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset: READYI=%b STROBEO=%b, required 1/0", READYI, STROBEO);
        end
    endtask

    task automatic test_zero();
        int acc;
        logic [64:0] e, g;
        READYO = 1'b1;
        fill_block(0);
        send_block(acc);
        wait_got(4);
        vectors++;
        if (got_cyc.size() < 4 || got_cyc[0] != acc + 1 || got_cyc[3] != acc + 4) begin
            miscompares++;
            $display("FAIL zero_latency: first beat cycle %0d, required %0d (beats seen %0d)",
                     (got_cyc.size() > 0) ? got_cyc[0] : -1, acc + 1, got_cyc.size());
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (got_q.size() == 0) begin miscompares++; $display("FAIL zero_block: beat missing, required %h", e); end
            else begin
                g = got_q.pop_front();
                if (g !== e) begin miscompares++; $display("FAIL zero_block: {last,data} %h, required %h", g, e); end
            end
        end
        flush();
    endtask

    task automatic test_patterns();
        int acc;
        logic [15:0] lit;
        logic [64:0] e, g;
        READYO = 1'b1;
        for (int p = 0; p < 4; p++) begin
            case (p)
                0: begin fill_block(1);    lit = 16'd16;    end
                1: begin fill_block(-256); lit = 16'hF000;  end
                2: begin fill_block(255);  lit = 16'd4080;  end
                default: begin fill_block(0); xb[0][0] = 1; lit = 16'd1; end
            endcase
            send_block(acc);
            wait_got(4);
            vectors++;
            if (got_q.size() == 0) begin miscompares++; $display("FAIL pattern%0d_y00: no beat, required %h", p, lit); end
            else if (got_q[0][15:0] !== lit) begin
                miscompares++;
                $display("FAIL pattern%0d_y00: got %h, required %h", p, got_q[0][15:0], lit);
            end
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                if (got_q.size() == 0) begin miscompares++; $display("FAIL pattern%0d: beat missing, required %h", p, e); end
                else begin
                    g = got_q.pop_front();
                    if (g !== e) begin miscompares++; $display("FAIL pattern%0d: {last,data} %h, required %h", p, g, e); end
                end
            end
            flush();
        end
    endtask

    task automatic test_hold();
        int acc;
        logic [64:0] e, g;
        READYO = 1'b0;
        rand_block();
        send_block(acc);
        @(posedge CLK);
        #1;
        vectors++;
        if (STROBEO !== 1'b1 || DATAO !== exp_q[0][63:0]) begin
            miscompares++;
            $display("FAIL hold_row0: STROBEO=%b DATAO=%h, required 1/%h", STROBEO, DATAO, exp_q[0][63:0]);
        end
        READYO = 1'b1;
        @(posedge CLK);
        #1;
        READYO = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge CLK);
            #1;
            vectors++;
            if (STROBEO !== 1'b1 || LASTO !== 1'b0 || DATAO !== exp_q[1][63:0]) begin
                miscompares++;
                $display("FAIL hold_row1: STROBEO=%b LASTO=%b DATAO=%h, required 1/0/%h",
                         STROBEO, LASTO, DATAO, exp_q[1][63:0]);
            end
        end
        READYO = 1'b1;
        wait_got(4);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (got_q.size() == 0) begin miscompares++; $display("FAIL hold_block: beat missing, required %h", e); end
            else begin
                g = got_q.pop_front();
                if (g !== e) begin miscompares++; $display("FAIL hold_block: {last,data} %h, required %h", g, e); end
            end
        end
        flush();
    endtask

    task automatic test_back_to_back();
        int acc;
        logic [64:0] e, g;
        READYO = 1'b0;
        rand_block();
        send_block(acc);
        rand_block();
        send_block(acc);
        for (int c = 0; c < 3; c++) begin
            @(posedge CLK);
            #1;
            vectors++;
            if (READYI !== 1'b0) begin miscompares++; $display("FAIL b2b_readyi_low: got %b, required 0", READYI); end
        end
        rand_block();
        fork
            send_block(acc);
            READYO = 1'b1;
        join
        wait_got(12);
        vectors++;
        if (got_cyc.size() < 5 || blk_rdy_cyc != got_cyc[3] + 1 || got_cyc[4] != got_cyc[3] + 1) begin
            miscompares++;
            $display("FAIL b2b_timing: READYI rose at cycle %0d, required %0d; beats seen %0d",
                     blk_rdy_cyc, (got_cyc.size() > 3) ? got_cyc[3] + 1 : -1, got_cyc.size());
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (got_q.size() == 0) begin miscompares++; $display("FAIL b2b_block: beat missing, required %h", e); end
            else begin
                g = got_q.pop_front();
                if (g !== e) begin miscompares++; $display("FAIL b2b_block: {last,data} %h, required %h", g, e); end
            end
        end
        flush();
    endtask

    task automatic test_random();
        int acc, t;
        bit done;
        logic [64:0] e, g;
        done = 1'b0;
        fork
            begin
                for (int b = 0; b < 6; b++) begin
                    rand_block();
                    send_block(acc);
                end
                done = 1'b1;
            end
            begin
                t = 0;
                while ((!done || got_q.size() < 24) && t < 3000) begin
                    READYO = 1'($urandom_range(0, 1));
                    @(posedge CLK);
                    #1;
                    t++;
                end
                READYO = 1'b1;
            end
        join
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (got_q.size() == 0) begin miscompares++; $display("FAIL random_block: beat missing, required %h", e); end
            else begin
                g = got_q.pop_front();
                if (g !== e) begin miscompares++; $display("FAIL random_block: {last,data} %h, required %h", g, e); end
            end
        end
        vectors++;
        if (got_q.size() != 0) begin miscompares++; $display("FAIL random_extra: %0d extra beats, required 0", got_q.size()); end
        flush();
    endtask

    task automatic test_reset_mid();
        int acc;
        logic [64:0] e, g;
        READYO = 1'b1;
        rand_block();
        send_row(0, acc);
        send_row(1, acc);
        RESET_N = 1'b0;
        #1;
        vectors++;
        if (READYI !== 1'b1 || STROBEO !== 1'b0 || LASTO !== 1'b0 || DATAO !== 64'd0) begin
            miscompares++;
            $display("FAIL reset_partial: READYI=%b STROBEO=%b LASTO=%b DATAO=%h, required 1/0/0/0",
                     READYI, STROBEO, LASTO, DATAO);
        end
        @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        flush();
        READYO = 1'b0;
        rand_block();
        send_block(acc);
        @(posedge CLK);
        #1;
        READYO = 1'b1;
        repeat (2) begin
            @(posedge CLK);
            #1;
        end
        READYO = 1'b0;
        vectors++;
        if (STROBEO !== 1'b1 || DATAO !== exp_q[2][63:0]) begin
            miscompares++;
            $display("FAIL reset_out2_pre: STROBEO=%b DATAO=%h, required 1/%h", STROBEO, DATAO, exp_q[2][63:0]);
        end
        RESET_N = 1'b0;
        #1;
        vectors++;
        if (READYI !== 1'b1 || STROBEO !== 1'b0 || LASTO !== 1'b0 || DATAO !== 64'd0) begin
            miscompares++;
            $display("FAIL reset_out2: READYI=%b STROBEO=%b LASTO=%b DATAO=%h, required 1/0/0/0",
                     READYI, STROBEO, LASTO, DATAO);
        end
        @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        flush();
        READYO = 1'b1;
        rand_block();
        send_block(acc);
        wait_got(4);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (got_q.size() == 0) begin miscompares++; $display("FAIL reset_recover: beat missing, required %h", e); end
            else begin
                g = got_q.pop_front();
                if (g !== e) begin miscompares++; $display("FAIL reset_recover: {last,data} %h, required %h", g, e); end
            end
        end
        flush();
    endtask

    initial begin
        RESET_N = 1'b1;
        STROBEI = 1'b0;
        DATAI   = '0;
        READYO  = 1'b1;
        test_reset();
        test_zero();
        test_patterns();
        test_hold();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
